// File: rtl/ldpc_pkg.sv
// Shared LDPC iteration-control definitions: FSM state encoding, default
// code dimensions and the H_t column extraction helper.
package ldpc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_CHECK,
    S_DECIDE,
    S_DONE
  } ldpc_state_e;

  localparam int LDPC_N_DEF        = 6;
  localparam int LDPC_K_DEF        = 3;
  localparam int LDPC_MAX_ITER_DEF = 8;

  // Widest H_t and syndrome the column helper can handle.
  localparam int LDPC_HT_MAXW = 1024;
  localparam int LDPC_SW_MAXW = 128;

  // Column j of a transposed parity-check matrix with sw-bit columns packed
  // LSB-first. The caller truncates the result to its syndrome width.
  function automatic logic [LDPC_SW_MAXW-1:0] ldpc_col(
    input logic [LDPC_HT_MAXW-1:0] ht,
    input int                      sw,
    input int                      j
  );
    return LDPC_SW_MAXW'(ht >> (j * sw));
  endfunction

endpackage

// File: rtl/ldpc_iter_ctrl_synd_accum.sv
// Serial syndrome accumulator: folds one H_t column per cycle into the
// syndrome whenever the matching codeword bit is set.
module synd_accum #(
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [SW-1:0] col,
  input  logic          cw_bit,
  output logic [SW-1:0] syndrome
);

  logic [SW-1:0] synd_q;

  // Clear wins over accumulate; XOR in the column only for set bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                synd_q <= '0;
    else if (clr)           synd_q <= '0;
    else if (en && cw_bit)  synd_q <= synd_q ^ col;
  end

  assign syndrome = synd_q;

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC decoder iteration controller. Issues one iter_go per iteration,
// latches the hard decisions, checks the syndrome serially (one H_t column
// per cycle) and decides whether to stop.
// Build option: LDPC_ITER_CTRL_EARLY_TERM_EN -- when defined, a zero syndrome
// ends the decode early; otherwise every decode runs MAX_ITER iterations.
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int N        = LDPC_N_DEF,
  parameter int K        = LDPC_K_DEF,
  parameter int MAX_ITER = LDPC_MAX_ITER_DEF,
  parameter int ITER_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*(N-K)-1:0]   H_t,
  input  logic                 start,
  output logic                 iter_go,
  input  logic                 iter_done,
  input  logic [N-1:0]         hd,
  output logic                 busy,
  output logic                 done,
  output logic                 success,
  output logic [N-1:0]         cw_out,
  output logic [ITER_W-1:0]    iter_cnt
);

  localparam int               SW       = N - K;
  localparam int               CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(N - 1);
  localparam logic [ITER_W-1:0] CNT_MAX = ITER_W'(MAX_ITER);

  ldpc_state_e        state_q;
  logic               busy_q, done_q, go_q, succ_q;
  logic [N-1:0]       cw_q;
  logic [ITER_W-1:0]  cnt_q, iter_cnt_d;
  logic [CW-1:0]      col_q;

  logic [SW-1:0]      col_w;
  logic [SW-1:0]      syndrome;
  logic               synd_zero;
  logic               synd_clr;
  logic               stop;

  // Current H_t column selected by the CHECK column counter.
  assign col_w     = SW'(ldpc_col(LDPC_HT_MAXW'(H_t), SW, int'(col_q)));
  assign synd_zero = (syndrome == '0);

  // Syndrome restarts with every accepted decode and every accepted iteration.
  assign synd_clr  = ((state_q == S_IDLE) && start) ||
                     ((state_q == S_ITER) && iter_done);

  // Saturating iteration count; never wraps past MAX_ITER.
  assign iter_cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef LDPC_ITER_CTRL_EARLY_TERM_EN
  assign stop = synd_zero || (cnt_q == CNT_MAX);
`else
  assign stop = (cnt_q == CNT_MAX);
`endif

  synd_accum #(.SW(SW)) u_synd (
    .clk      (clk),
    .rst      (rst),
    .clr      (synd_clr),
    .en       (state_q == S_CHECK),
    .col      (col_w),
    .cw_bit   (cw_q[col_q]),
    .syndrome (syndrome)
  );

  // Control FSM with registered outputs; go/done are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
      succ_q  <= 1'b0;
      cw_q    <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
    end else begin
      go_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ITER;
            busy_q  <= 1'b1;
            go_q    <= 1'b1;
            succ_q  <= 1'b0;
            cw_q    <= '0;
            cnt_q   <= '0;
          end
        end
        S_ITER: begin
          if (iter_done) begin
            cw_q    <= hd;
            cnt_q   <= iter_cnt_d;
            col_q   <= '0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (col_q == COL_LAST) state_q <= S_DECIDE;
          else                   col_q   <= col_q + 1'b1;
        end
        S_DECIDE: begin
          if (stop) begin
            succ_q  <= synd_zero;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            go_q    <= 1'b1;
            state_q <= S_ITER;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign iter_go  = go_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign success  = succ_q;
  assign cw_out   = cw_q;
  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl (N=6, K=3, MAX_ITER=4).
// Model: per decode, predicts the cycle of each iter_go / done pulse from the
// iter_done timing and the syndrome computed directly from H_t.
module tb_ldpc_iter_ctrl;

  localparam int N    = 6;
  localparam int K    = 3;
  localparam int MAXI = 4;
`ifdef LDPC_ITER_CTRL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk, rst, start, iter_done;
  logic [17:0] Ht;
  logic [5:0]  hd;
  logic        iter_go, busy, done, success;
  logic [5:0]  cw_out;
  logic [7:0]  iter_cnt;

  ldpc_iter_ctrl #(.N(N), .K(K), .MAX_ITER(MAXI), .ITER_W(8)) dut (
    .clk(clk), .rst(rst), .H_t(Ht), .start(start), .iter_go(iter_go),
    .iter_done(iter_done), .hd(hd), .busy(busy), .done(done),
    .success(success), .cw_out(cw_out), .iter_cnt(iter_cnt)
  );

  typedef struct {
    bit         succ;
    logic [5:0] cw;
    int         cnt;
  } res_t;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   go_at[int];
  bit   done_at[int];
  bit   busy_on[int];
  bit   busy_off[int];
  res_t res_at[int];
  bit   eb;
  res_t er;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] synd(input logic [5:0] v);
    logic [2:0] s;
    s = '0;
    for (int j = 0; j < 6; j++)
      if (v[j]) s ^= Ht[j*3 +: 3];
    return s;
  endfunction

  function automatic res_t mkres(input bit s, input logic [5:0] cw, input int cnt);
    res_t r;
    r.succ = s; r.cw = cw; r.cnt = cnt;
    return r;
  endfunction

  task automatic model_reset();
    go_at.delete(); done_at.delete(); busy_on.delete(); busy_off.delete(); res_at.delete();
    eb = 0;
    er = mkres(0, '0, 0);
  endtask

  // Per-cycle comparison of the DUT against the scheduled model events.
  initial begin
    eb = 0;
    er = mkres(0, '0, 0);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_iter_go", iter_go, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_success", success, 0);
        chk("rst_cw_out", cw_out, 0);
        chk("rst_iter_cnt", iter_cnt, 0);
      end else begin
        if (busy_on.exists(cyc))  eb = 1;
        if (busy_off.exists(cyc)) eb = 0;
        if (res_at.exists(cyc))   er = res_at[cyc];
        chk("iter_go", iter_go, go_at.exists(cyc));
        chk("done", done, done_at.exists(cyc));
        chk("busy", busy, eb);
        if (!eb) begin
          chk("success", success, er.succ);
          chk("cw_out", cw_out, er.cw);
          chk("iter_cnt", iter_cnt, er.cnt);
        end
      end
    end
  end

  // One decode: start, answer each iter_go with an iter_done carrying seq[i].
  // With inject, a stray iter_done and a stray start land during CHECK.
  task automatic run_decode(input logic [3:0][5:0] seq, input bit inject, output int ngo);
    int c, dcyc, it;
    bit term, ok;
    logic [2:0] s;
    ngo = 0;
    dcyc = 0;
    @(posedge clk); #1;
    start = 1; c = cyc;
    go_at[c+1] = 1; busy_on[c+1] = 1; res_at[c+1] = mkres(0, '0, 0);
    @(posedge clk); #1;
    start = 0;
    term = 0; it = 0;
    while (!term) begin
      ok = 0;
      for (int w = 0; w < 40 && !ok; w++) begin
        if (iter_go) ok = 1;
        else begin @(posedge clk); #1; end
      end
      if (!ok) begin
        nchk++; nerr++;
        $display("FAIL go_timeout: no iter_go within 40 cycles (cycle %0d)", cyc);
        return;
      end
      ngo++;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      it++;
      iter_done = 1; hd = seq[it-1]; c = cyc;
      s = synd(hd);
      term = (it == MAXI) || (EARLY && s == 3'd0);
      if (term) begin
        dcyc = c + N + 2;
        done_at[dcyc] = 1; busy_off[dcyc] = 1;
        res_at[dcyc] = mkres(s == 3'd0, hd, it);
      end else begin
        go_at[c+N+2] = 1;
      end
      @(posedge clk); #1;
      iter_done = 0; hd = 6'($urandom);
      if (inject) begin
        @(posedge clk); #1;
        iter_done = 1; hd = 6'($urandom);
        @(posedge clk); #1;
        iter_done = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
      end
    end
    while (cyc <= dcyc) begin @(posedge clk); #1; end
  endtask

  // Start a decode and reset it mid-ITER (mid_check=0) or mid-CHECK (1).
  task automatic abort_decode(input bit mid_check);
    int c;
    @(posedge clk); #1;
    start = 1; c = cyc;
    go_at[c+1] = 1; busy_on[c+1] = 1; res_at[c+1] = mkres(0, '0, 0);
    @(posedge clk); #1;
    start = 0;
    if (mid_check) begin
      iter_done = 1; hd = 6'b011001;
      @(posedge clk); #1;
      iter_done = 0;
    end
    repeat (2) begin @(posedge clk); #1; end
    if (mid_check) start = 1;
    @(posedge clk); #1;
    start = 0;
    rst = 1;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    repeat (N + 6) begin @(posedge clk); #1; end
    chk("abort_busy", busy, 0);
    chk("abort_cw_out", cw_out, 0);
    chk("abort_iter_cnt", iter_cnt, 0);
  endtask

  initial begin
    logic [3:0][5:0] seq;
    logic [5:0]      v;
    int              ngo;
    Ht = 18'b100_010_001_110_101_011;
    rst = 1; start = 0; iter_done = 0; hd = '0;

    v = 6'b011001;
    chk("model_synd_011001", synd(v), 3'b000);
    v = 6'b000001;
    chk("model_synd_000001", synd(v), 3'b011);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Codeword valid on the first iteration.
    seq = {4{6'b011001}};
    run_decode(seq, 0, ngo);
    chk("t1_go_count", ngo, EARLY ? 1 : 4);
    chk("t1_success", success, 1);
    chk("t1_cw_out", cw_out, 6'b011001);
    chk("t1_iter_cnt", iter_cnt, EARLY ? 1 : 4);

    // Never converges: runs to MAX_ITER.
    seq = {4{6'b000001}};
    run_decode(seq, 0, ngo);
    chk("t2_go_count", ngo, 4);
    chk("t2_success", success, 0);
    chk("t2_iter_cnt", iter_cnt, 4);

    // Converges on the third iteration.
    seq[0] = 6'b000001; seq[1] = 6'b000001; seq[2] = 6'b011001; seq[3] = 6'b011001;
    run_decode(seq, 0, ngo);
    chk("t3_go_count", ngo, EARLY ? 3 : 4);
    chk("t3_success", success, 1);
    chk("t3_iter_cnt", iter_cnt, EARLY ? 3 : 4);

    // Stray start / iter_done while busy are ignored.
    seq = {4{6'b000001}};
    run_decode(seq, 1, ngo);
    chk("t4_go_count", ngo, 4);
    chk("t4_iter_cnt", iter_cnt, 4);

    // Reset aborts a decode with no done.
    abort_decode(1);
    abort_decode(0);

    // Randomized decodes.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 2))
          0:       seq[i] = 6'b011001;
          1:       seq[i] = 6'b000001;
          default: seq[i] = 6'($urandom);
        endcase
      end
      run_decode(seq, 1'($urandom_range(0, 1)), ngo);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ldpc_iter_ctrl.md
LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

Interface
REQ-001 SHALL have parameter N, default 6: codeword length.
REQ-002 SHALL have parameter K, default 3: information length; syndrome width is N-K.
REQ-003 SHALL have parameter MAX_ITER, default 8: maximum decoder iterations per codeword (range 1..255).
REQ-004 SHALL have parameter ITER_W, default 8: iteration counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 H_t  input  N*(N-K)  transposed parity-check matrix; column j is H_t[(j+1)*(N-K)-1 : j*(N-K)]; static while busy.
REQ-008 start  input  1  one-cycle request to decode one codeword.
REQ-009 iter_go  output  1  one-cycle pulse commanding the decoder datapath to run one iteration.
REQ-010 iter_done  input  1  one-cycle pulse from the datapath; the iteration is complete and hd is valid.
REQ-011 hd  input  N  hard decisions, sampled only on the cycle iter_done is high.
REQ-012 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-013 done  output  1  one-cycle pulse; the decode is finished.
REQ-014 success  output  1  final syndrome was zero; valid with done, held until the next start.
REQ-015 cw_out  output  N  last sampled hd; valid with done, held until the next start.
REQ-016 iter_cnt  output  ITER_W  iterations executed; valid with done, held until the next start.

Function
REQ-017 FSM states SHALL be IDLE, ITER, CHECK, DECIDE, DONE.
REQ-018 IDLE: start=1 -> ITER; clear syndrome, iter_cnt, success, cw_out; iter_go pulses on the first ITER cycle.
REQ-019 ITER: wait for iter_done; on iter_done latch hd into cw_out, increment iter_cnt, clear syndrome, col=0 -> CHECK.
REQ-020 CHECK SHALL take exactly N cycles: syndrome ^= col_j(H_t) when cw_out[j]=1, j=0..N-1, one column per cycle.
REQ-021 DECIDE: if syndrome==0 or iter_cnt==MAX_ITER -> DONE with success=(syndrome==0); else -> ITER with a new iter_go pulse.
REQ-022 DONE: assert done for one cycle, deassert busy -> IDLE.
REQ-023 Latency from iter_done to done (terminating iteration) SHALL be N+2 cycles.
REQ-024 start while busy SHALL be ignored; iter_done outside ITER SHALL be ignored.
REQ-025 iter_go SHALL never be asserted more than once per iteration, nor more than MAX_ITER times per decode.
REQ-026 iter_cnt SHALL saturate at MAX_ITER and never wrap.

Reset
REQ-027 rst SHALL force IDLE and set busy, done, iter_go, success, cw_out, iter_cnt, syndrome and col to 0, including mid-ITER or mid-CHECK; no done is produced for an aborted decode.

Configuration
REQ-028 With LDPC_ITER_CTRL_EARLY_TERM_EN defined, DECIDE SHALL terminate on a zero syndrome as in REQ-021.
REQ-029 Without it, DECIDE SHALL terminate only when iter_cnt==MAX_ITER; success still equals (final syndrome==0).

Structure
REQ-030 The state enum, default N/K/MAX_ITER constants and the column-extract helper SHALL live in shared package ldpc_pkg.
REQ-031 The serial column XOR accumulator SHALL be sub-module synd_accum (clear, enable, column, bit -> syndrome).

Verification (N=6, K=3, MAX_ITER=4, H_t=18'b100_010_001_110_101_011)
REQ-032 Assert rst mid-sequence -> next cycle all outputs 0, state IDLE.
REQ-033 start; hd=6'b011001 on first iter_done -> done 8 cycles after iter_done, success=1, iter_cnt=1, cw_out=6'b011001, one iter_go total.
REQ-034 start; hd=6'b000001 on every iter_done -> exactly 4 iter_go pulses, done, success=0, iter_cnt=4.
REQ-035 start; hd=6'b000001, 6'b000001, then 6'b011001 -> success=1, iter_cnt=3, 3 iter_go pulses.
REQ-036 start pulsed while busy, and rst asserted during CHECK -> second start ignored; after rst, busy=0 and no done pulse appears.
REQ-037 Macro undefined, stimulus of REQ-033 -> 4 iter_go pulses, success=1, iter_cnt=4.
